// File: rtl/cross_cov_counter.sv
// A x B cross-coverage collector: one saturating hit counter per bin, illegal-sample count, closure vs AT_LEAST.
// Statistics and read data update one cycle after the sampling edge; no backpressure, one sample and one read per cycle.
module cross_cov_counter #(
  parameter int NUM_A    = 4,
  parameter int NUM_B    = 3,
  parameter int CNT_W    = 8,
  parameter int AT_LEAST = 1,
  localparam int A_W     = (NUM_A > 1) ? $clog2(NUM_A) : 1,
  localparam int B_W     = (NUM_B > 1) ? $clog2(NUM_B) : 1,
  localparam int NBINS   = NUM_A * NUM_B,
  localparam int IDX_W   = (NBINS > 1) ? $clog2(NBINS) : 1,
  localparam int CC_W    = $clog2(NBINS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [A_W-1:0]   sample_a,
  input  logic [B_W-1:0]   sample_b,
  input  logic             clear,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic [CNT_W-1:0] illegal_count,
  output logic [CC_W-1:0]  covered_count,
  output logic             all_covered
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GOAL_M1  = CNT_W'(AT_LEAST - 1);

  logic [CNT_W-1:0] bin_q [NBINS];
  logic [CNT_W-1:0] bin_d [NBINS];
  logic [CNT_W-1:0] illegal_q, illegal_d;
  logic [CC_W-1:0]  covered_q, covered_d;
  logic             all_cov_q, all_cov_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  logic             legal;
  logic [IDX_W-1:0] samp_idx;

  assign legal    = ({1'b0, sample_a} < NUM_A[A_W:0]) && ({1'b0, sample_b} < NUM_B[B_W:0]);
  assign samp_idx = IDX_W'(sample_a) * IDX_W'(NUM_B) + IDX_W'(sample_b);

  always_comb begin
    for (int i = 0; i < NBINS; i++) begin
      bin_d[i] = bin_q[i];
    end
    illegal_d = illegal_q;
    covered_d = covered_q;

    if (sample_valid && legal) begin
      for (int i = 0; i < NBINS; i++) begin
        if (samp_idx == IDX_W'(i) && bin_q[i] != CNT_MAX) begin
          bin_d[i] = bin_q[i] + CNT_W'(1);
          // Only the AT_LEAST-1 -> AT_LEAST transition closes a bin.
          if (bin_q[i] == GOAL_M1) begin
            covered_d = covered_q + CC_W'(1);
          end
        end
      end
    end else if (sample_valid && illegal_q != CNT_MAX) begin
      illegal_d = illegal_q + CNT_W'(1);
    end

    // Clear discards any sample landing on the same edge.
    if (clear) begin
      for (int i = 0; i < NBINS; i++) begin
        bin_d[i] = '0;
      end
      illegal_d = '0;
      covered_d = '0;
    end

    all_cov_d = (covered_d == CC_W'(NBINS));
  end

  // Reads see pre-edge bin values and are independent of clear.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < NBINS; i++) begin
        if (rd_idx == IDX_W'(i)) begin
          rd_data_d = bin_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NBINS; i++) begin
        bin_q[i] <= '0;
      end
      illegal_q  <= '0;
      covered_q  <= '0;
      all_cov_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      for (int i = 0; i < NBINS; i++) begin
        bin_q[i] <= bin_d[i];
      end
      illegal_q  <= illegal_d;
      covered_q  <= covered_d;
      all_cov_q  <= all_cov_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign illegal_count = illegal_q;
  assign covered_count = covered_q;
  assign all_covered   = all_cov_q;

endmodule
